// File: rtl/sc_pkg.sv
// ---------------------------------------------------------------------------
// sc_pkg
// Shared types and constants for the stochastic scaled-adder slice.
//   sc_state_e    : control FSM states (IDLE, RUN)
//   LFSR_TAPS     : feedback mask for the 8-bit Fibonacci LFSR (taps 8,6,5,4)
//   LFSR_SEED_DEF : default LFSR seed
//   lfsr_next()   : one LFSR step (shift left, XOR of tapped bits enters LSB)
// ---------------------------------------------------------------------------
package sc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sc_state_e;

  // Taps 8,6,5,4 counted from 1 map to bit positions 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS     = 8'b1011_1000;
  localparam logic [7:0] LFSR_SEED_DEF = 8'hA5;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/sc_sel_gen.sv
// ---------------------------------------------------------------------------
// sc_sel_gen
// Select generator for the N-way stochastic mux.
// Default build: wrap-around counter 0..2**SEL_W-1, advancing on step.
// With macro SC_LFSR_SEL_EN: sel is the low SEL_W bits of an 8-bit Fibonacci
// LFSR (taps 8,6,5,4) that is reseeded with LFSR_SEED on rst and load.
// Ports:
//   clk   in  clock
//   rst   in  synchronous active-high reset
//   load  in  restart the select sequence (window start)
//   step  in  advance the select (one accepted bit)
//   sel   out current select
// ---------------------------------------------------------------------------
module sc_sel_gen
  import sc_pkg::*;
#(
  parameter int SEL_W = 2
`ifdef SC_LFSR_SEL_EN
  ,
  parameter logic [7:0] LFSR_SEED = LFSR_SEED_DEF
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  output logic [SEL_W-1:0] sel
);

`ifdef SC_LFSR_SEL_EN

  logic [7:0] lfsr;

  always_ff @(posedge clk) begin
    if (rst || load) begin
      lfsr <= LFSR_SEED;
    end else if (step) begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  assign sel = lfsr[SEL_W-1:0];

`else

  logic [SEL_W-1:0] cnt;

  // N_IN is a power of two, so natural overflow is the wrap to 0.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      cnt <= '0;
    end else if (step) begin
      cnt <= cnt + SEL_W'(1);
    end
  end

  assign sel = cnt;

`endif

endmodule

// File: rtl/sc_mux_scaled_adder.sv
// ---------------------------------------------------------------------------
// sc_mux_scaled_adder
// N-input stochastic scaled adder: each accepted bit in RUN muxes
// in_bits[sel] onto out_bit and counts ones over a WIN_LEN-bit window.
// sum / WIN_LEN approximates (1/N_IN) * sum(P_i).
// Optional macro SC_LFSR_SEL_EN: LFSR-driven select instead of a counter.
// Ports:
//   clk        in  clock
//   rst        in  synchronous active-high reset
//   start      in  begin a window (sampled in IDLE only)
//   in_valid   in  in_bits valid this cycle
//   in_bits    in  one bit from each of the N_IN streams
//   out_bit    out selected stream bit, registered
//   out_valid  out out_bit valid
//   sel        out select applied to the next accepted bit
//   busy       out high while in RUN
//   sum        out ones count of the last completed window
//   sum_valid  out one-cycle pulse when sum updates
// ---------------------------------------------------------------------------
module sc_mux_scaled_adder
  import sc_pkg::*;
#(
  parameter int         N_IN      = 4,
  parameter int         SEL_W     = $clog2(N_IN),
  parameter int         WIN_LEN   = 256,
  parameter int         CNT_W     = $clog2(WIN_LEN + 1),
  parameter logic [7:0] LFSR_SEED = LFSR_SEED_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [N_IN-1:0]  in_bits,
  output logic             out_bit,
  output logic             out_valid,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic [CNT_W-1:0] sum,
  output logic             sum_valid
);

  // Elaboration-time guard on the parameter set.
  if (N_IN < 2 || (N_IN & (N_IN - 1)) != 0 || (WIN_LEN % N_IN) != 0 ||
      LFSR_SEED == 8'h00) begin : g_param_check
    $error("sc_mux_scaled_adder: illegal N_IN/WIN_LEN/LFSR_SEED");
  end

  sc_state_e        state, state_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] ones_cnt;
  logic             accept;
  logic             last;
  logic             load;
  logic             cur_bit;

  assign accept  = (state == RUN) && in_valid;
  assign last    = accept && (bit_cnt == CNT_W'(WIN_LEN - 1));
  assign load    = (state == IDLE) && start;
  assign cur_bit = in_bits[sel];

  sc_sel_gen #(
    .SEL_W    (SEL_W)
`ifdef SC_LFSR_SEL_EN
    ,
    .LFSR_SEED(LFSR_SEED)
`endif
  ) u_sel_gen (
    .clk (clk),
    .rst (rst),
    .load(load),
    .step(accept),
    .sel (sel)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: the default assignment first keeps this combinational process from
  // inferring a latch on paths that do not change state.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
  end

  // Datapath: output mux register, window counters and result register.
  // The window-closing bit is folded into sum directly so sum_valid lines up
  // with that bit's out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_bit   <= 1'b0;
      out_valid <= 1'b0;
      sum       <= '0;
      sum_valid <= 1'b0;
      bit_cnt   <= '0;
      ones_cnt  <= '0;
    end else begin
      out_valid <= accept;
      sum_valid <= last;
      if (load) begin
        bit_cnt  <= '0;
        ones_cnt <= '0;
      end
      if (accept) begin
        out_bit  <= cur_bit;
        bit_cnt  <= bit_cnt + CNT_W'(1);
        ones_cnt <= ones_cnt + CNT_W'(cur_bit);
      end
      if (last) begin
        sum <= ones_cnt + CNT_W'(cur_bit);
      end
    end
  end

endmodule

// File: tb/tb_sc_mux_scaled_adder.sv
// ---------------------------------------------------------------------------
// tb_sc_mux_scaled_adder
// Self-checking bench for sc_mux_scaled_adder with N_IN=4, WIN_LEN=8.
// Expected values come from a window-level model: the k-th accepted bit of
// a window takes input exp_sel(k), and sum is the count of ones taken.
// ---------------------------------------------------------------------------
module tb_sc_mux_scaled_adder;

  localparam int N_IN    = 4;
  localparam int SEL_W   = 2;
  localparam int WIN_LEN = 8;
  localparam int CNT_W   = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             in_valid;
  logic [N_IN-1:0]  in_bits;
  logic             out_bit;
  logic             out_valid;
  logic [SEL_W-1:0] sel;
  logic             busy;
  logic [CNT_W-1:0] sum;
  logic             sum_valid;

  int tests_run    = 0;
  int tests_failed = 0;
  int last_sum     = 0;

  always #5 clk = ~clk;

  sc_mux_scaled_adder #(
    .N_IN   (N_IN),
    .WIN_LEN(WIN_LEN)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_bits  (in_bits),
    .out_bit  (out_bit),
    .out_valid(out_valid),
    .sel      (sel),
    .busy     (busy),
    .sum      (sum),
    .sum_valid(sum_valid)
  );

  // Select expected before the k-th accepted bit of a window.
  function automatic logic [SEL_W-1:0] exp_sel(input int k);
`ifdef SC_LFSR_SEL_EN
    logic [7:0] l;
    l = 8'hA5;
    for (int i = 0; i < k; i++) l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    return l[SEL_W-1:0];
`else
    return SEL_W'(k % N_IN);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one window and checks it cycle by cycle; returns the ones count.
  task automatic run_window(input bit do_start, input int vmode,
                            input bit rand_bits, input logic [N_IN-1:0] fixed_bits,
                            input bit start_noise, input int held_sum,
                            output int ones);
    int k;
    bit done;
    bit acc;
    logic [N_IN-1:0] b;
    logic exp_bit;
    logic last_bit;
    k = 0; ones = 0; done = 1'b0; last_bit = 1'b0;
    if (do_start) begin
      start = 1'b1; in_valid = 1'b0;
      tick();
      start = 1'b0;
      tests_run++;
      if (busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL busy_after_start: got %b want 1", busy);
      end
    end
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      case (vmode)
        0:       acc = 1'b1;
        1:       acc = (cyc % 2) == 0;
        default: acc = ($urandom_range(3) != 0);
      endcase
      b = rand_bits ? N_IN'($urandom) : fixed_bits;
      in_valid = acc; in_bits = b;
      start = start_noise ? 1'($urandom_range(1)) : 1'b0;
      tests_run++;
      if (sel !== exp_sel(k)) begin
        tests_failed++;
        $display("FAIL sel k=%0d: got %0d want %0d", k, sel, exp_sel(k));
      end
      exp_bit = b[exp_sel(k)];
      tick();
      tests_run++;
      if (out_valid !== acc) begin
        tests_failed++;
        $display("FAIL out_valid cyc=%0d: got %b want %b", cyc, out_valid, acc);
      end
      if (acc) begin
        tests_run++;
        if (out_bit !== exp_bit) begin
          tests_failed++;
          $display("FAIL out_bit k=%0d: got %b want %b", k, out_bit, exp_bit);
        end
        k++;
        ones += int'(exp_bit);
        last_bit = exp_bit;
      end else if (k > 0) begin
        tests_run++;
        if (out_bit !== last_bit) begin
          tests_failed++;
          $display("FAIL out_bit_hold cyc=%0d: got %b want %b", cyc, out_bit, last_bit);
        end
      end
      if (acc && k == WIN_LEN) begin
        done = 1'b1;
        tests_run++;
        if (sum_valid !== 1'b1 || sum !== CNT_W'(ones) || busy !== 1'b0) begin
          tests_failed++;
          $display("FAIL window_end: got sv=%b sum=%0d busy=%b want sv=1 sum=%0d busy=0",
                   sum_valid, sum, busy, ones);
        end
      end else begin
        tests_run++;
        if (sum_valid !== 1'b0 || busy !== 1'b1 || sum !== CNT_W'(held_sum)) begin
          tests_failed++;
          $display("FAIL in_window cyc=%0d: got sv=%b busy=%b sum=%0d want sv=0 busy=1 sum=%0d",
                   cyc, sum_valid, busy, sum, held_sum);
        end
      end
    end
    in_valid = 1'b0; start = 1'b0;
    if (!done) begin
      tests_run++;
      tests_failed++;
      $display("FAIL window_timeout: got %0d accepted bits want %0d", k, WIN_LEN);
    end
  endtask

  // One IDLE cycle with in_valid high: nothing may be accepted.
  task automatic check_idle(input int exp_sum);
    in_valid = 1'b1; in_bits = N_IN'($urandom); start = 1'b0;
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (sum_valid !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 ||
        sum !== CNT_W'(exp_sum) || sel !== exp_sel(WIN_LEN)) begin
      tests_failed++;
      $display("FAIL idle: got sv=%b ov=%b busy=%b sum=%0d sel=%0d want 0/0/0/%0d/%0d",
               sum_valid, out_valid, busy, sum, sel, exp_sum, exp_sel(WIN_LEN));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_bits = '0;
    tick();
    tick();
    rst = 1'b0;
    tests_run++;
    if (out_bit !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 ||
        sum_valid !== 1'b0 || sum !== '0 || sel !== exp_sel(0)) begin
      tests_failed++;
      $display("FAIL reset: got ob=%b ov=%b busy=%b sv=%b sum=%0d sel=%0d",
               out_bit, out_valid, busy, sum_valid, sum, sel);
    end
  endtask

  task automatic test_basic();
    int ones;
    run_window(1'b1, 0, 1'b0, 4'b0011, 1'b0, last_sum, ones);
`ifndef SC_LFSR_SEL_EN
    tests_run++;
    if (sum !== CNT_W'(4)) begin
      tests_failed++;
      $display("FAIL basic_sum: got %0d want 4", sum);
    end
`endif
    last_sum = ones;
    check_idle(last_sum);
  endtask

  task automatic test_ones_zeros();
    int ones;
    run_window(1'b1, 0, 1'b0, 4'b1111, 1'b0, last_sum, ones);
    tests_run++;
    if (sum !== CNT_W'(8)) begin
      tests_failed++;
      $display("FAIL all_ones_sum: got %0d want 8", sum);
    end
    last_sum = ones;
    check_idle(last_sum);
    run_window(1'b1, 0, 1'b0, 4'b0000, 1'b0, last_sum, ones);
    tests_run++;
    if (sum !== CNT_W'(0)) begin
      tests_failed++;
      $display("FAIL all_zeros_sum: got %0d want 0", sum);
    end
    last_sum = ones;
    check_idle(last_sum);
  endtask

  task automatic test_valid_toggle();
    int ones;
    run_window(1'b1, 1, 1'b0, 4'b0011, 1'b0, last_sum, ones);
    last_sum = ones;
    check_idle(last_sum);
  endtask

  task automatic test_random();
    int ones;
    for (int w = 0; w < 4; w++) begin
      run_window(1'b1, 2, 1'b1, '0, 1'b0, last_sum, ones);
      last_sum = ones;
      check_idle(last_sum);
    end
  endtask

  task automatic test_reset_mid_run();
    int ones;
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_bits = N_IN'($urandom);
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests_run++;
    if (sum_valid !== 1'b0 || sum !== '0 || sel !== exp_sel(0) ||
        busy !== 1'b0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_run: got sv=%b sum=%0d sel=%0d busy=%b ov=%b",
               sum_valid, sum, sel, busy, out_valid);
    end
    tick();
    tests_run++;
    if (sum_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_run_after: got sv=%b busy=%b want 0/0", sum_valid, busy);
    end
    last_sum = 0;
    run_window(1'b1, 0, 1'b1, '0, 1'b0, last_sum, ones);
    last_sum = ones;
    check_idle(last_sum);
  endtask

  task automatic test_back_to_back();
    int ones;
    run_window(1'b1, 2, 1'b1, '0, 1'b1, last_sum, ones);
    last_sum = ones;
    // sum_valid is high now; start in this cycle begins the next window.
    start = 1'b1; in_valid = 1'b0;
    tick();
    start = 1'b0;
    tests_run++;
    if (busy !== 1'b1 || sum_valid !== 1'b0 || sum !== CNT_W'(last_sum)) begin
      tests_failed++;
      $display("FAIL back_to_back_start: got busy=%b sv=%b sum=%0d want 1/0/%0d",
               busy, sum_valid, sum, last_sum);
    end
    run_window(1'b0, 0, 1'b1, '0, 1'b1, last_sum, ones);
    last_sum = ones;
    check_idle(last_sum);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ones_zeros();
    test_valid_toggle();
    test_random();
    test_reset_mid_run();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
